adc_spi_frame_tx: RTL and testbench



---
 rtl/adc_link_pkg.sv | 24 ++
 rtl/spi_half_bit_timer.sv | 29 ++
 rtl/adc_spi_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_adc_spi_frame_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_link_pkg.sv
// Shared definitions for the Addatone ADC control link: frame geometry,
// word order and the SPI transmitter state encoding.
package adc_link_pkg;

    localparam int NUM_WORDS  = 5;
    localparam int WORD_BITS  = 16;
    localparam int FRAME_BITS = NUM_WORDS * WORD_BITS;

    // Word positions within a frame; word 0 is transmitted first.
    localparam int IDX_FREQ       = 0;
    localparam int IDX_HARM_SCALE = 1;
    localparam int IDX_SCALE_INIT = 2;
    localparam int IDX_FREQ_SCALE = 3;
    localparam int IDX_COMB       = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/spi_half_bit_timer.sv
// Counts core clocks within one SCK half period and flags the last one.
// Cleared whenever the owning FSM changes state so each state starts aligned.
module spi_half_bit_timer #(
    parameter int CLKS_PER_HALF_BIT = 4
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Clear,
    output logic o_Half_Tick
);

    localparam int CW = $clog2(CLKS_PER_HALF_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_HALF_BIT - 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset || i_Clear) begin
            count_q <= '0;
        end else if (count_q == LAST) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 1'b1;
        end
    end

    assign o_Half_Tick = (count_q == LAST);

endmodule

// File: rtl/adc_spi_frame_tx.sv
// SPI mode-0 master sending one 80-bit control frame (five 16-bit words).
// Optional build macro ADC_TX_AUTO_REPEAT_EN adds a periodic frame request.
module adc_spi_frame_tx
    import adc_link_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 4
`ifdef ADC_TX_AUTO_REPEAT_EN
    , parameter logic [15:0] FRAME_INTERVAL = 16'd48000
`endif
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic [15:0] i_Data0,
    input  logic [15:0] i_Data1,
    input  logic [15:0] i_Data2,
    input  logic [15:0] i_Data3,
    input  logic [15:0] i_Data4,
    input  logic        i_Send,
    output logic        o_Ready,
    output logic        o_Done,
    output logic        o_SPI_CS,
    output logic        o_SPI_Clock,
    output logic        o_SPI_Data,
    output logic [2:0]  o_State
);

    // Handshake: a frame is accepted on any edge where o_Ready=1 and the
    // request is high; requests while busy are dropped, never queued.

    tx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d, frame_load;
    logic [6:0]            bit_cnt_q, bit_cnt_d;
    logic                  sck_q, sck_d;
    logic                  cs_q, cs_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;
    logic                  gap_half_q, gap_half_d;
    logic                  half_tick;
    logic                  send_req;
    logic [WORD_BITS-1:0]  words [NUM_WORDS];

    assign words[IDX_FREQ]       = i_Data0;
    assign words[IDX_HARM_SCALE] = i_Data1;
    assign words[IDX_SCALE_INIT] = i_Data2;
    assign words[IDX_FREQ_SCALE] = i_Data3;
    assign words[IDX_COMB]       = i_Data4;

    always_comb begin
        frame_load = '0;
        for (int w = 0; w < NUM_WORDS; w++) begin
            frame_load[FRAME_BITS-1-w*WORD_BITS -: WORD_BITS] = words[w];
        end
    end

`ifdef ADC_TX_AUTO_REPEAT_EN
    logic [15:0] interval_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            interval_q <= '0;
        end else if (interval_q == FRAME_INTERVAL - 16'd1) begin
            interval_q <= '0;
        end else begin
            interval_q <= interval_q + 16'd1;
        end
    end

    assign send_req = i_Send | (interval_q == 16'd0);
`else
    assign send_req = i_Send;
`endif

    spi_half_bit_timer #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_timer (
        .i_Clock    (i_Clock),
        .i_Reset    (i_Reset),
        .i_Clear    (state_d != state_q),
        .o_Half_Tick(half_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        sck_d      = 1'b0;
        done_d     = 1'b0;
        gap_half_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (send_req) begin
                    state_d   = SETUP;
                    shift_d   = frame_load;
                    bit_cnt_d = '0;
                end
            end
            SETUP: begin
                if (half_tick) state_d = SHIFT;
            end
            SHIFT: begin
                sck_d = sck_q;
                if (half_tick) begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        // The final bit stays on MOSI through HOLD.
                        if (bit_cnt_q == 7'(FRAME_BITS - 1)) begin
                            state_d = HOLD;
                        end else begin
                            shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 7'd1;
                        end
                    end
                end
            end
            HOLD: begin
                if (half_tick) begin
                    state_d = GAP;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                gap_half_d = gap_half_q;
                if (half_tick) begin
                    if (gap_half_q) state_d = IDLE;
                    else            gap_half_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        cs_d   = !(state_d inside {SETUP, SHIFT, HOLD});
        mosi_d = cs_d ? 1'b0 : shift_d[FRAME_BITS-1];
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            gap_half_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            gap_half_q <= gap_half_d;
        end
    end

    assign o_Ready     = (state_q == IDLE);
    assign o_Done      = done_q;
    assign o_SPI_CS    = cs_q;
    assign o_SPI_Clock = sck_q;
    assign o_SPI_Data  = mosi_q;
    assign o_State     = state_q;

endmodule

// File: tb/tb_adc_spi_frame_tx.sv
// Bench for adc_spi_frame_tx: two instances (half-bit 4 and 2) watched by an
// SPI slave model; captured frames are scored against a frame-level model.
module tb_adc_spi_frame_tx;

    localparam int FI = 2000;

    typedef struct {
        int          inst;
        logic [79:0] val;
        int          nbits;
    } rec_t;

    typedef struct {
        int inst;
        int len;
    } gap_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic [1:0]      send = 2'b00;
    logic [15:0]     d0, d1, d2, d3, d4;
    logic [1:0]      ready, done, cs, sck, mosi;
    logic [1:0][2:0] st;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            adc_spi_frame_tx #(
                .CLKS_PER_HALF_BIT(g == 0 ? 4 : 2)
`ifdef ADC_TX_AUTO_REPEAT_EN
                , .FRAME_INTERVAL(16'(FI))
`endif
            ) dut (
                .i_Clock    (clk),
                .i_Reset    (rst),
                .i_Data0    (d0),
                .i_Data1    (d1),
                .i_Data2    (d2),
                .i_Data3    (d3),
                .i_Data4    (d4),
                .i_Send     (send[g]),
                .o_Ready    (ready[g]),
                .o_Done     (done[g]),
                .o_SPI_CS   (cs[g]),
                .o_SPI_Clock(sck[g]),
                .o_SPI_Data (mosi[g]),
                .o_State    (st[g])
            );
        end
    endgenerate

    // scoreboard state
    logic [80:0] exp_q[$];
    rec_t        rec_q[$];
    gap_t        gap_q[$];
    int          fall_q[$];
    int          errors = 0;
    int          checks = 0;

    // SPI slave model
    logic [79:0] cap [2];
    int          nb [2];
    int          run [2];
    int          done_cnt [2];
    logic [1:0]  cs_p = 2'b11;
    logic [1:0]  sck_p = 2'b00;
    int          viol = 0;
    int          cyc = 0;
    rec_t        mon_r;
    gap_t        mon_g;

    initial begin
        for (int i = 0; i < 2; i++) begin
            cap[i] = '0; nb[i] = 0; run[i] = 0; done_cnt[i] = 0;
        end
    end

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                nb[i] = 0; cap[i] = '0; run[i] = 0;
            end else begin
                if (cs[i] && sck[i]) viol++;
                if (!cs[i] && sck[i] && !sck_p[i]) begin
                    cap[i] = {cap[i][78:0], mosi[i]};
                    nb[i]++;
                end
                if (cs[i] && !cs_p[i]) begin
                    mon_r.inst = i; mon_r.val = cap[i]; mon_r.nbits = nb[i];
                    rec_q.push_back(mon_r);
                    cap[i] = '0; nb[i] = 0;
                end
                if (cs[i]) run[i]++;
                if (!cs[i] && cs_p[i]) begin
                    mon_g.inst = i; mon_g.len = run[i];
                    gap_q.push_back(mon_g);
                    if (i == 0) fall_q.push_back(cyc);
                    run[i] = 0;
                end
                if (done[i]) done_cnt[i]++;
            end
            cs_p[i]  = cs[i];
            sck_p[i] = sck[i];
        end
    end

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int half_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    // Frame duration from its phases: setup, 80 two-half bits, hold, gap.
    function automatic int lat_of(input int i);
        int h;
        h = half_of(i);
        return h + 80 * 2 * h + h + 2 * h;
    endfunction

    task automatic set_data(input logic [15:0] a, b, c, e, f);
        d0 = a; d1 = b; d2 = c; d3 = e; d4 = f;
    endtask

    task automatic check_frame();
        rec_t        r;
        logic [80:0] e;
        if (rec_q.size() == 0 || exp_q.size() == 0) begin
            chk("frame_present", 96'(rec_q.size()), 96'(1));
        end else begin
            r = rec_q.pop_front();
            e = exp_q.pop_front();
            chk("frame_data", {15'd0, r.inst[0], r.val}, {15'd0, e});
            chk("sck_rises", 96'(r.nbits), 96'(80));
        end
    endtask

    // driver: mode 0 plain, 1 re-pulse i_Send while busy, 2 change word0 mid-frame
    task automatic run_frame(input int i, input int mode);
        int n;
        int dc;
        dc = done_cnt[i];
        @(negedge clk);
        chk("ready_before", 96'(ready[i]), 96'(1));
        send[i] = 1'b1;
        exp_q.push_back({i[0], d0, d1, d2, d3, d4});
        @(posedge clk);
        #1 send[i] = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (ready[i]) break;
            @(posedge clk);
            n++;
            #1;
            if (mode == 1) send[i] = (n == 10 || n == 300);
            if (mode == 2 && n == 50) d0 = 16'hFFFF;
        end
        chk("latency", 96'(n), 96'(lat_of(i)));
        repeat (2) @(negedge clk);
        chk("done_count", 96'(done_cnt[i] - dc), 96'(1));
        check_frame();
        chk("extra_frames", 96'(rec_q.size()), 96'(0));
    endtask

    task automatic run_b2b(input int i);
        int k;
        int n;
        @(negedge clk);
        send[i] = 1'b1;
        for (int f = 0; f < 3; f++) exp_q.push_back({i[0], d0, d1, d2, d3, d4});
        n = 0;
        while (cs[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        gap_q.delete();
        k = 0;
        n = 0;
        while (k < 3 && n < 5000) begin
            @(negedge clk);
            if (done[i]) k++;
            n++;
        end
        send[i] = 1'b0;
        chk("b2b_done", 96'(k), 96'(3));
        n = 0;
        while (!ready[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk("b2b_gaps", 96'(gap_q.size()), 96'(2));
        while (gap_q.size() > 0) begin
            mon_g = gap_q.pop_front();
            chk("b2b_gap_len", 96'(mon_g.len), 96'(2 * half_of(i) + 1));
        end
        for (int f = 0; f < 3; f++) check_frame();
        chk("extra_frames", 96'(rec_q.size()), 96'(0));
    endtask

    task automatic run_abort();
        int dc;
        dc = done_cnt[0];
        @(negedge clk);
        send[0] = 1'b1;
        @(posedge clk);
        #1 send[0] = 1'b0;
        repeat (199) @(posedge clk);
        @(negedge clk);
        chk("abort_cs_low", 96'(cs[0]), 96'(0));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_cs", 96'(cs[0]), 96'(1));
        chk("abort_sck", 96'(sck[0]), 96'(0));
        chk("abort_mosi", 96'(mosi[0]), 96'(0));
        chk("abort_ready", 96'(ready[0]), 96'(1));
        chk("abort_done", 96'(done[0]), 96'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 96'(done_cnt[0] - dc), 96'(0));
        chk("abort_no_frame", 96'(rec_q.size()), 96'(0));
    endtask

    initial begin
        set_data(16'hA5C3, 16'h010E, 16'h01FF, 16'h0000, 16'h0003);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 96'(cs), 96'(2'b11));
        chk("rst_sck", 96'(sck), 96'(0));
        chk("rst_mosi", 96'(mosi), 96'(0));
        chk("rst_ready", 96'(ready), 96'(2'b11));
        chk("rst_done", 96'(done), 96'(0));
        chk("rst_state", 96'(st[0]), 96'(0));
        @(posedge clk);
        #1 rst = 1'b0;

`ifdef ADC_TX_AUTO_REPEAT_EN
        repeat (2 * FI + 900) @(posedge clk);
        @(negedge clk);
        chk("auto_falls", 96'(fall_q.size() >= 3), 96'(1));
        for (int k = 0; k < 3 && k < fall_q.size(); k++)
            chk("auto_fall_cycle", 96'(fall_q[k]), 96'(1 + k * FI));
        for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, d0, d1, d2, d3, d4});
        for (int k = 0; k < rec_q.size(); k++) begin
            if (rec_q[k].inst == 0 && exp_q.size() > 0) begin
                chk("auto_frame", {16'd0, rec_q[k].val}, {15'd0, exp_q.pop_front()});
                chk("auto_sck_rises", 96'(rec_q[k].nbits), 96'(80));
            end
        end
        chk("auto_frames_seen", 96'(exp_q.size()), 96'(0));
        rec_q.delete();
`else
        run_frame(0, 0);
        set_data(16'hA5C3, 16'h010E, 16'h01FF, 16'h0000, 16'h0003);
        run_frame(0, 2);
        set_data(16'hA5C3, 16'h010E, 16'h01FF, 16'h0000, 16'h0003);
        run_frame(0, 1);
        run_abort();
        run_frame(0, 0);
        run_b2b(0);
        set_data(16'h1234, 16'h8001, 16'h7FFE, 16'hFFFF, 16'h5A5A);
        run_b2b(1);
        for (int k = 0; k < 4; k++) begin
            set_data(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            run_frame(int'($urandom_range(0, 1)), 0);
        end
`endif
        chk("sck_while_cs_high", 96'(viol), 96'(0));
        chk("scoreboard_empty", 96'(exp_q.size()), 96'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
